// File: rtl/platformer_pkg.sv
// Shared types and tile helpers for the platformer player physics block.
package platformer_pkg;

    localparam int TILE_SHIFT_D = 5;

    typedef enum logic [3:0] {
        IDLE, XCALC, XP0, XW0, XP1, XW1,
        YCALC, YP0, YW0, YP1, YW1, COMMIT
    } phys_state_t;

    // Floor division by tile size; negative coordinates land in negative tiles.
    function automatic int tile_of(input int c, input int ts);
        return c >>> ts;
    endfunction

    function automatic logic in_map(input int col, input int row, input int w, input int h);
        return (col >= 0) && (col < w) && (row >= 0) && (row < h);
    endfunction

endpackage

// File: rtl/platformer_physics_if.sv
// Tile bitmap read port between the physics FSM (master) and the tile map (slave).
interface platformer_physics_if #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
);
    logic                     map_rd;
    logic [$clog2(MAP_W)-1:0] map_col;
    logic [$clog2(MAP_H)-1:0] map_row;
    logic                     map_hit;

    modport master (output map_rd, map_col, map_row, input map_hit);
    modport slave  (input map_rd, map_col, map_row, output map_hit);
endinterface

// File: rtl/platformer_physics_tile_map_rom.sv
// Tile bitmap with a 1-cycle registered read; bit index is row*MAP_W+col.
module tile_map_rom #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
) (
    input  logic                   clk_pix,
    input  logic [MAP_W*MAP_H-1:0] tiles,
    platformer_physics_if.slave    map
);
    localparam int IW = $clog2(MAP_W*MAP_H);

    logic [IW-1:0] idx;
    assign idx = IW'(int'(map.map_row) * MAP_W + int'(map.map_col));

    always_ff @(posedge clk_pix) begin
        if (map.map_rd) map.map_hit <= tiles[idx];
    end
endmodule

// File: rtl/platformer_physics.sv
// Per-frame player physics: walk, multi-jump, gravity, then wall/floor/ceiling
// resolution against the tile map through four fixed-slot probes.
module platformer_physics
    import platformer_pkg::*;
#(
    parameter int CORDW      = 10,
    parameter int TILE_SHIFT = TILE_SHIFT_D,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int Q_SIZE     = 32,
    parameter int GRAVITY    = 1,
    parameter int JUMP_V     = 10,
    parameter int MAX_FALL   = 15,
    parameter int WALK_V     = 5,
    parameter int MAX_JUMPS  = 2,
    parameter int X0         = 200,
    parameter int Y0         = 100
) (
    input  logic                             clk_pix,
    input  logic                             rst_pix,
    input  logic                             frame,
    input  logic                             key_left,
    input  logic                             key_right,
    input  logic                             key_up,
    platformer_physics_if.master             map,
    output logic [CORDW-1:0]                 qx,
    output logic [CORDW-1:0]                 qy,
    output logic signed [7:0]                qv,
    output logic [$clog2(MAX_JUMPS+1)-1:0]   jumps_left,
    output logic                             grounded,
    output logic                             busy,
    output logic                             done
);
    localparam int CW      = CORDW + 2;
    localparam int COLW    = $clog2(MAP_W);
    localparam int ROWW    = $clog2(MAP_H);
    localparam int JW      = $clog2(MAX_JUMPS + 1);
    localparam int TILE_SZ = 1 << TILE_SHIFT;

    typedef logic signed [CW-1:0] cand_t;
    typedef logic signed [7:0]    vel_t;

    phys_state_t   state;
    cand_t         xc_r, nx_r, yc_r, ny_r, lead_r, pcol_r, prow_r;
    vel_t          v_r, nv_r;
    logic          mv_r, mv_l, up_r, jump_r, hit0_r, oob_r, key_up_prev, ngr_r;
    logic [JW-1:0] nj_r;

    int   dx, xc, xcol, xrow0, xrow1, vg, v, yc, ycol0, ycol1, yrow;
    logic jump, hit_now, x_hit, y_hit;

    // Out-of-map probes still strobe the port, but at tile (0,0).
    function automatic logic [COLW-1:0] clamp_col(input int c, input int r);
        return in_map(c, r, MAP_W, MAP_H) ? COLW'(c) : '0;
    endfunction

    function automatic logic [ROWW-1:0] clamp_row(input int c, input int r);
        return in_map(c, r, MAP_W, MAP_H) ? ROWW'(r) : '0;
    endfunction

    always_comb begin
        dx = 0;
        if (key_right && !key_left)      dx = WALK_V;
        else if (key_left && !key_right) dx = -WALK_V;
        xc    = int'(qx) + dx;
        xcol  = tile_of((dx > 0) ? xc + Q_SIZE - 1 : xc, TILE_SHIFT);
        xrow0 = tile_of(int'(qy), TILE_SHIFT);
        xrow1 = tile_of(int'(qy) + Q_SIZE - 1, TILE_SHIFT);

        jump = key_up && !key_up_prev && (jumps_left != '0);
        vg   = int'(qv) + GRAVITY;
        if (vg > MAX_FALL) vg = MAX_FALL;
        v     = jump ? -JUMP_V : vg;
        yc    = int'(qy) + v;
        ycol0 = tile_of(int'(nx_r), TILE_SHIFT);
        ycol1 = tile_of(int'(nx_r) + Q_SIZE - 1, TILE_SHIFT);
        yrow  = tile_of((v >= 0) ? yc + Q_SIZE - 1 : yc, TILE_SHIFT);

        hit_now = oob_r | map.map_hit;
        x_hit   = hit0_r | hit_now;
        y_hit   = hit0_r | hit_now;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= IDLE;
            qx          <= CORDW'(X0);
            qy          <= CORDW'(Y0);
            qv          <= '0;
            jumps_left  <= JW'(MAX_JUMPS);
            grounded    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            map.map_rd  <= 1'b0;
            map.map_col <= '0;
            map.map_row <= '0;
            key_up_prev <= 1'b0;
            hit0_r      <= 1'b0;
            oob_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (frame) begin
                    busy  <= 1'b1;
                    state <= XCALC;
                end
                XCALC: begin
                    mv_r        <= dx > 0;
                    mv_l        <= dx < 0;
                    xc_r        <= cand_t'(xc);
                    lead_r      <= cand_t'(xcol);
                    pcol_r      <= cand_t'(xcol);
                    prow_r      <= cand_t'(xrow1);
                    map.map_rd  <= 1'b1;
                    map.map_col <= clamp_col(xcol, xrow0);
                    map.map_row <= clamp_row(xcol, xrow0);
                    oob_r       <= !in_map(xcol, xrow0, MAP_W, MAP_H);
                    state       <= XP0;
                end
                XP0, XP1, YP0, YP1: begin
                    map.map_rd <= 1'b0;
                    state      <= state.next();
                end
                XW0, YW0: begin
                    hit0_r      <= hit_now;
                    map.map_rd  <= 1'b1;
                    map.map_col <= clamp_col(int'(pcol_r), int'(prow_r));
                    map.map_row <= clamp_row(int'(pcol_r), int'(prow_r));
                    oob_r       <= !in_map(int'(pcol_r), int'(prow_r), MAP_W, MAP_H);
                    state       <= state.next();
                end
                XW1: begin
                    if (x_hit && mv_r)      nx_r <= cand_t'(int'(lead_r) * TILE_SZ - Q_SIZE);
                    else if (x_hit && mv_l) nx_r <= cand_t'((int'(lead_r) + 1) * TILE_SZ);
                    else                    nx_r <= xc_r;
                    state <= YCALC;
                end
                YCALC: begin
                    v_r         <= vel_t'(v);
                    up_r        <= v < 0;
                    jump_r      <= jump;
                    yc_r        <= cand_t'(yc);
                    lead_r      <= cand_t'(yrow);
                    pcol_r      <= cand_t'(ycol1);
                    prow_r      <= cand_t'(yrow);
                    map.map_rd  <= 1'b1;
                    map.map_col <= clamp_col(ycol0, yrow);
                    map.map_row <= clamp_row(ycol0, yrow);
                    oob_r       <= !in_map(ycol0, yrow, MAP_W, MAP_H);
                    state       <= YP0;
                end
                YW1: begin
                    if (y_hit && !up_r) begin
                        ny_r  <= cand_t'(int'(lead_r) * TILE_SZ - Q_SIZE);
                        nv_r  <= '0;
                        ngr_r <= 1'b1;
                        nj_r  <= JW'(MAX_JUMPS);
                    end else begin
                        ny_r  <= y_hit ? cand_t'((int'(lead_r) + 1) * TILE_SZ) : yc_r;
                        nv_r  <= y_hit ? vel_t'(0) : v_r;
                        ngr_r <= 1'b0;
                        nj_r  <= jump_r ? jumps_left - JW'(1) : jumps_left;
                    end
                    state <= COMMIT;
                end
                COMMIT: begin
                    qx          <= nx_r[CORDW-1:0];
                    qy          <= ny_r[CORDW-1:0];
                    qv          <= nv_r;
                    grounded    <= ngr_r;
                    jumps_left  <= nj_r;
                    key_up_prev <= key_up;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_platformer_physics.sv
// Randomized and directed check of platformer_physics against a frame-level model.
module tb_platformer_physics;

    logic         clk_pix = 1'b0;
    logic         rst_pix = 1'b1;
    logic         frame = 1'b0, key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
    logic [299:0] tiles = '0;
    logic [9:0]   qx, qy;
    logic signed [7:0] qv;
    logic [1:0]   jumps_left;
    logic         grounded, busy, done;

    int n_cmp = 0, n_bad = 0;
    int mqx, mqy, mqv, mj;
    bit mg, mprev;

    always #5 clk_pix = ~clk_pix;

    platformer_physics_if map_if ();

    platformer_physics dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame),
        .key_left(key_left), .key_right(key_right), .key_up(key_up),
        .map(map_if), .qx(qx), .qy(qy), .qv(qv), .jumps_left(jumps_left),
        .grounded(grounded), .busy(busy), .done(done)
    );

    tile_map_rom #(.MAP_W(20), .MAP_H(15)) rom (
        .clk_pix(clk_pix), .tiles(tiles), .map(map_if)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---- reference model: 32px tiles on a 20x15 map, outside the map is solid
    function automatic int fdiv(input int a);
        return (a >= 0) ? a / 32 : -((-a + 31) / 32);
    endfunction

    function automatic bit solid(input int c, input int r);
        if (c < 0 || c >= 20 || r < 0 || r >= 15) return 1'b1;
        return tiles[r*20 + c];
    endfunction

    task automatic model_reset();
        mqx = 200; mqy = 100; mqv = 0; mj = 2; mg = 0; mprev = 0;
    endtask

    task automatic model_step(input bit kl, input bit kr, input bit ku);
        int dx, xc, nx, c, v, yc, r;
        bit jmp, hit;
        dx = (kr && !kl) ? 5 : (kl && !kr) ? -5 : 0;
        xc = mqx + dx;
        nx = xc;
        if (dx > 0) begin
            c = fdiv(xc + 31);
            if (solid(c, fdiv(mqy)) || solid(c, fdiv(mqy + 31))) nx = c * 32 - 32;
        end else if (dx < 0) begin
            c = fdiv(xc);
            if (solid(c, fdiv(mqy)) || solid(c, fdiv(mqy + 31))) nx = (c + 1) * 32;
        end
        jmp = ku && !mprev && (mj > 0);
        v   = jmp ? -10 : ((mqv + 1 > 15) ? 15 : mqv + 1);
        yc  = mqy + v;
        r   = (v >= 0) ? fdiv(yc + 31) : fdiv(yc);
        hit = solid(fdiv(nx), r) || solid(fdiv(nx + 31), r);
        if (hit && v >= 0) begin
            mqy = r * 32 - 32; mqv = 0; mg = 1; mj = 2;
        end else begin
            mqy = hit ? (r + 1) * 32 : yc;
            mqv = hit ? 0 : v;
            mg  = 0;
            if (jmp) mj--;
        end
        mqx = nx;
        mprev = ku;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".qx"}, int'(qx), mqx);
        chk({tag, ".qy"}, int'(qy), mqy);
        chk({tag, ".qv"}, int'(qv), mqv);
        chk({tag, ".jumps"}, int'(jumps_left), mj);
        chk({tag, ".grounded"}, int'(grounded), int'(mg));
    endtask

    task automatic do_reset();
        @(negedge clk_pix);
        rst_pix = 1'b1; frame = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_up = 1'b0;
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input string tag, input bit kl, input bit kr, input bit ku);
        bit seen;
        @(negedge clk_pix);
        key_left = kl; key_right = kr; key_up = ku; frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk_pix);
        end
        if (!seen) chk({tag, ".done_timeout"}, 0, 1);
        model_step(kl, kr, ku);
        check_state(tag);
    endtask

    task automatic set_row(input int r);
        for (int c = 0; c < 20; c++) tiles[r*20 + c] = 1'b1;
    endtask

    task automatic set_col(input int c);
        for (int r = 0; r < 15; r++) tiles[r*20 + c] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_mask, busy_mask, done_mask, dcnt;

        // reset state
        tiles = '0;
        set_row(14);
        do_reset();
        check_state("reset");
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.map_rd", int'(map_if.map_rd), 0);

        // fixed latency, probe slots, and a frame while busy is ignored
        @(negedge clk_pix);
        frame = 1'b1;
        rd_mask = 0; busy_mask = 0; done_mask = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_pix);
            rd_mask   |= int'(map_if.map_rd) << k;
            busy_mask |= int'(busy) << k;
            done_mask |= int'(done) << k;
            frame = (k == 5);
        end
        chk("timing.map_rd_cycles", rd_mask, (1 << 2) | (1 << 4) | (1 << 7) | (1 << 9));
        chk("timing.busy_cycles", busy_mask, 32'hFFE);
        chk("timing.done_cycles", done_mask, 1 << 12);
        model_step(1'b0, 1'b0, 1'b0);
        check_state("timing");

        // free fall onto row 14
        for (int f = 0; f < 40; f++) run_frame("fall", 1'b0, 1'b0, 1'b0);
        chk("land.qy", int'(qy), 416);
        chk("land.qv", int'(qv), 0);
        chk("land.grounded", int'(grounded), 1);
        chk("land.jumps", int'(jumps_left), 2);

        // double jump, third press refused
        run_frame("jump1", 1'b0, 1'b0, 1'b1);
        chk("jump1.qv", int'(qv), -10);
        chk("jump1.qy", int'(qy), 406);
        chk("jump1.jumps", int'(jumps_left), 1);
        run_frame("rel1", 1'b0, 1'b0, 1'b0);
        run_frame("jump2", 1'b0, 1'b0, 1'b1);
        chk("jump2.jumps", int'(jumps_left), 0);
        run_frame("rel2", 1'b0, 1'b0, 1'b0);
        run_frame("jump3", 1'b0, 1'b0, 1'b1);
        chk("jump3.jumps", int'(jumps_left), 0);
        for (int f = 0; f < 40; f++) run_frame("fall2", 1'b0, 1'b0, 1'b0);
        // key held across frames only jumps once
        for (int f = 0; f < 3; f++) run_frame("hold", 1'b0, 1'b0, 1'b1);
        chk("hold.jumps", int'(jumps_left), 1);
        for (int f = 0; f < 40; f++) run_frame("fall3", 1'b0, 1'b0, 1'b0);

        // ceiling: row 12 directly above the grounded sprite
        set_row(12);
        run_frame("ceil", 1'b0, 1'b0, 1'b1);
        chk("ceil.qy", int'(qy), 416);
        chk("ceil.qv", int'(qv), 0);

        // wall at column 10
        tiles = '0;
        set_row(14);
        set_col(10);
        do_reset();
        for (int f = 0; f < 25; f++) run_frame("walk", 1'b0, 1'b1, 1'b0);
        chk("wall.qx", int'(qx), 288);
        for (int f = 0; f < 3; f++) run_frame("push", 1'b0, 1'b1, 1'b0);
        chk("wall.qx_held", int'(qx), 288);
        run_frame("both", 1'b1, 1'b1, 1'b0);
        chk("both.qx", int'(qx), 288);
        run_frame("left", 1'b1, 1'b0, 1'b0);

        // reset in the middle of an update
        @(negedge clk_pix);
        frame = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_pix);
            frame = 1'b0;
        end
        rst_pix = 1'b1;
        @(negedge clk_pix);
        rst_pix = 1'b0;
        model_reset();
        chk("midrst.busy", int'(busy), 0);
        check_state("midrst");
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            dcnt += int'(done);
            @(negedge clk_pix);
        end
        chk("midrst.no_done", dcnt, 0);
        run_frame("midrst.next", 1'b0, 1'b0, 1'b0);

        // random maps and key streams
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 300; i++) tiles[i] = ($urandom_range(0, 99) < 10);
            set_row(14);
            for (int r = 2; r <= 5; r++)
                for (int c = 5; c <= 8; c++) tiles[r*20 + c] = 1'b0;
            do_reset();
            for (int f = 0; f < 150; f++)
                run_frame("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
